kf6845_bus_initiator: RTL and testbench

Host-side bus master for the KF6845 CRTC register interface. It drives the 6845-style CPU bus (CS_N, RS, ENABLE, R_OR_W, data) to perform complete indirect register accesses: an address-register write (RS=0) followed by a data-register write or read (RS=1). Commands arrive on a valid/ready port, and read results return on a one-cycle response strobe. It sits between a system sequencer or soft CPU and the KF6845 bus control logic.

---
 rtl/kf6845_bus_initiator_if.sv | 45 ++++
 rtl/kf6845_bus_initiator.sv | 242 ++++++++++++++++++++++++
 tb/tb_kf6845_bus_initiator.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kf6845_bus_initiator_if.sv
// -----------------------------------------------------------------------------
// kf6845_bus_initiator_if
//
// Bundles the command/response handshake and the 6845-style CPU bus driven by
// kf6845_bus_initiator. The clock and reset stay as plain ports on the modules.
//
// Signals
//   cmd_valid, cmd_write, cmd_register[4:0], cmd_data[7:0]  command request
//   cmd_ready                                               command accept
//   rsp_valid, rsp_data[7:0]                                read response
//   CS_N, RS, ENABLE, R_OR_W, D_OUT[7:0], D_OE              CRTC bus (to chip)
//   D_IN[7:0]                                               CRTC bus (from chip)
//
// Modports
//   master : the bus initiator (accepts commands, drives the CRTC bus)
//   slave  : the environment (issues commands, models the CRTC)
// -----------------------------------------------------------------------------
interface kf6845_bus_initiator_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [4:0] cmd_register;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       CS_N;
  logic       RS;
  logic       ENABLE;
  logic       R_OR_W;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic [7:0] D_IN;

  modport master (
    input  cmd_valid, cmd_write, cmd_register, cmd_data, D_IN,
    output cmd_ready, rsp_valid, rsp_data,
           CS_N, RS, ENABLE, R_OR_W, D_OUT, D_OE
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_register, cmd_data, D_IN,
    input  cmd_ready, rsp_valid, rsp_data,
           CS_N, RS, ENABLE, R_OR_W, D_OUT, D_OE
  );
endinterface

// File: rtl/kf6845_bus_initiator.sv
// -----------------------------------------------------------------------------
// kf6845_bus_initiator
//
// Host-side bus master for the KF6845 CRTC register interface. Each accepted
// command becomes a complete indirect access: an address-register write
// (RS=0) carrying the register number, then a data-register write or read
// (RS=1). Read data is captured at the end of the data strobe and reported
// with a one-cycle rsp_valid pulse.
//
// Parameters
//   SETUP_CYCLES  (1..15) cycles of stable CS_N/RS/R_OR_W/data before ENABLE
//   ENABLE_CYCLES (1..15) cycles ENABLE is held high per phase
//
// Ports
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      kf6845_bus_initiator_if.master (command, response, CRTC bus)
//
// Build option
//   KF6845_ADDRESS_CACHE_EN  when defined, remembers the last register number
//   written in an address phase; a command to that same register skips the
//   address phase entirely. Undefined: every access has a full address phase.
//
// Every bus output is a flop whose next value is decoded from the next state,
// so outputs change only on clock edges and never glitch.
// -----------------------------------------------------------------------------
module kf6845_bus_initiator #(
  parameter int SETUP_CYCLES  = 1,
  parameter int ENABLE_CYCLES = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  kf6845_bus_initiator_if.master   bus
);

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] ENABLE_LAST = 4'(ENABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_SETUP = 3'd1,
    A_EN    = 3'd2,
    A_HOLD  = 3'd3,
    D_SETUP = 3'd4,
    D_EN    = 3'd5,
    D_HOLD  = 3'd6
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Latched command
  logic       write_q;
  logic [4:0] register_q;
  logic [7:0] data_q;

  // Command fields as seen by the next state (fresh on the accept edge)
  logic       write_eff;
  logic [4:0] register_eff;
  logic [7:0] data_eff;

  logic       accept;
  logic       cache_hit;
  logic       capture;

  // Next values of the registered outputs
  logic       cs_n_nxt;
  logic       rs_nxt;
  logic       enable_nxt;
  logic       r_or_w_nxt;
  logic [7:0] d_out_nxt;
  logic       d_oe_nxt;
  logic       cmd_ready_nxt;
  logic       rsp_valid_nxt;

  assign accept = bus.cmd_valid && bus.cmd_ready && (state == IDLE);

  assign write_eff    = accept ? bus.cmd_write    : write_q;
  assign register_eff = accept ? bus.cmd_register : register_q;
  assign data_eff     = accept ? bus.cmd_data     : data_q;

  // Read data is sampled on the edge that ends the last ENABLE cycle.
  assign capture = (state == D_EN) && (cnt == ENABLE_LAST) && !write_q;

`ifdef KF6845_ADDRESS_CACHE_EN
  logic       cache_valid;
  logic [4:0] cache_register;

  // An address phase counts as done once A_HOLD has been driven.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cache_valid <= 1'b0;
    end else if (state == A_HOLD) begin
      cache_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (state == A_HOLD) begin
      cache_register <= register_q;
    end
  end

  // cache_register is only meaningful once cache_valid is set.
  assign cache_hit = cache_valid && (bus.cmd_register == cache_register);
`else
  assign cache_hit = 1'b0;
`endif

  // Next-state and phase counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = cache_hit ? D_SETUP : A_SETUP;
          cnt_nxt   = 4'd0;
        end
      end
      A_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = A_EN;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      A_EN: begin
        if (cnt == ENABLE_LAST) begin
          state_nxt = A_HOLD;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      A_HOLD: begin
        state_nxt = D_SETUP;
        cnt_nxt   = 4'd0;
      end
      D_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = D_EN;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      D_EN: begin
        if (cnt == ENABLE_LAST) begin
          state_nxt = D_HOLD;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      D_HOLD: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Output decode from the next state, so flops present the state's values
  // during the cycle that state occupies.
  always_comb begin
    cs_n_nxt      = 1'b1;
    rs_nxt        = 1'b1;
    enable_nxt    = 1'b0;
    r_or_w_nxt    = 1'b1;
    d_out_nxt     = 8'hFF;
    d_oe_nxt      = 1'b0;
    cmd_ready_nxt = (state_nxt == IDLE);
    rsp_valid_nxt = capture;
    case (state_nxt)
      A_SETUP, A_EN, A_HOLD: begin
        cs_n_nxt   = 1'b0;
        rs_nxt     = 1'b0;
        r_or_w_nxt = 1'b0;
        d_out_nxt  = {3'b000, register_eff};
        d_oe_nxt   = 1'b1;
        enable_nxt = (state_nxt == A_EN);
      end
      D_SETUP, D_EN, D_HOLD: begin
        cs_n_nxt   = 1'b0;
        rs_nxt     = 1'b1;
        r_or_w_nxt = !write_eff;
        d_out_nxt  = write_eff ? data_eff : 8'hFF;
        d_oe_nxt   = write_eff;
        enable_nxt = (state_nxt == D_EN);
      end
      default: begin
        cs_n_nxt = 1'b1;
      end
    endcase
  end

  // ---- control and output register stage ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.CS_N      <= 1'b1;
      bus.RS        <= 1'b1;
      bus.ENABLE    <= 1'b0;
      bus.R_OR_W    <= 1'b1;
      bus.D_OUT     <= 8'hFF;
      bus.D_OE      <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 8'h00;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.CS_N      <= cs_n_nxt;
      bus.RS        <= rs_nxt;
      bus.ENABLE    <= enable_nxt;
      bus.R_OR_W    <= r_or_w_nxt;
      bus.D_OUT     <= d_out_nxt;
      bus.D_OE      <= d_oe_nxt;
      bus.cmd_ready <= cmd_ready_nxt;
      bus.rsp_valid <= rsp_valid_nxt;
      if (capture) begin
        bus.rsp_data <= bus.D_IN;
      end
    end
  end

  // ---- command latch stage (data only, no reset needed) ----
  always_ff @(posedge clock) begin
    if (accept) begin
      write_q    <= bus.cmd_write;
      register_q <= bus.cmd_register;
      data_q     <= bus.cmd_data;
    end
  end

endmodule

// File: tb/tb_kf6845_bus_initiator.sv
module tb_kf6845_bus_initiator;

`ifdef KF6845_ADDRESS_CACHE_EN
  localparam int HIT_CYCLES = 7;
  localparam int HIT_ADDR   = 0;
`else
  localparam int HIT_CYCLES = 13;
  localparam int HIT_ADDR   = 3;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  kf6845_bus_initiator_if bus_a ();
  kf6845_bus_initiator_if bus_b ();

  kf6845_bus_initiator #(.SETUP_CYCLES(1), .ENABLE_CYCLES(1)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a.master)
  );

  kf6845_bus_initiator #(.SETUP_CYCLES(2), .ENABLE_CYCLES(3)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b.master)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_write = 1'b0;
    bus_a.cmd_register = 5'd0; bus_a.cmd_data = 8'h00; bus_a.D_IN = 8'hFF;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_write = 1'b0;
    bus_b.cmd_register = 5'd0; bus_b.cmd_data = 8'h00; bus_b.D_IN = 8'hFF;
  endtask

  // Issue one command to dut_a; return the cycle index (accept edge = 0)
  // where cmd_ready is back, and the number of RS=0 ENABLE cycles seen.
  task automatic run_a(input logic wr, input logic [4:0] r, input logic [7:0] d,
                       output int cycles, output int addr_en);
    bus_a.cmd_valid = 1'b1; bus_a.cmd_write = wr;
    bus_a.cmd_register = r; bus_a.cmd_data = d;
    tick;
    bus_a.cmd_valid = 1'b0;
    cycles = 0; addr_en = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus_a.ENABLE && !bus_a.RS) addr_en++;
      if (bus_a.cmd_ready) begin cycles = c; break; end
      tick;
    end
  endtask

  task automatic run_b(input logic [4:0] r, input logic [7:0] d,
                       output int cycles, output int addr_en);
    bus_b.cmd_valid = 1'b1; bus_b.cmd_write = 1'b1;
    bus_b.cmd_register = r; bus_b.cmd_data = d;
    tick;
    bus_b.cmd_valid = 1'b0;
    cycles = 0; addr_en = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus_b.ENABLE && !bus_b.RS) addr_en++;
      if (bus_b.cmd_ready) begin cycles = c; break; end
      tick;
    end
  endtask

  task automatic test_reset;
    logic [6:0] ctl;
    idle_inputs();
    reset_n = 1'b0;
    repeat (10) tick;
    ctl = {bus_a.CS_N, bus_a.RS, bus_a.ENABLE, bus_a.R_OR_W, bus_a.D_OE,
           bus_a.cmd_ready, bus_a.rsp_valid};
    n_checks++;
    if (ctl !== 7'b1101000) $display("FAIL reset_ctl: got %b expected 1101000", ctl);
    else n_pass++;
    n_checks++;
    if (bus_a.D_OUT !== 8'hFF) $display("FAIL reset_dout: got %h expected ff", bus_a.D_OUT);
    else n_pass++;
    n_checks++;
    if (bus_a.rsp_data !== 8'h00) $display("FAIL reset_rsp_data: got %h expected 00", bus_a.rsp_data);
    else n_pass++;
    n_checks++;
    if (bus_b.cmd_ready !== 1'b0) $display("FAIL reset_ready_b: got %b expected 0", bus_b.cmd_ready);
    else n_pass++;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (bus_a.cmd_ready !== 1'b0) $display("FAIL ready_before_edge: got %b expected 0", bus_a.cmd_ready);
    else n_pass++;
    tick;
    n_checks++;
    if ({bus_a.cmd_ready, bus_b.cmd_ready} !== 2'b11)
      $display("FAIL ready_after_release: got %b expected 11", {bus_a.cmd_ready, bus_b.cmd_ready});
    else n_pass++;
  endtask

  task automatic test_write;
    int rsp_seen = 0;
    bus_a.cmd_valid = 1'b1; bus_a.cmd_write = 1'b1;
    bus_a.cmd_register = 5'h0E; bus_a.cmd_data = 8'h55;
    tick;
    // Change the command fields mid-access; the latched copy must be used.
    bus_a.cmd_valid = 1'b0; bus_a.cmd_register = 5'h1F; bus_a.cmd_data = 8'hAA;
    bus_a.cmd_write = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (bus_a.rsp_valid) rsp_seen++;
      if (c == 1) begin
        n_checks++;
        if ({bus_a.cmd_ready, bus_a.ENABLE, bus_a.CS_N, bus_a.RS} !== 4'b0000)
          $display("FAIL wr_c1: got %b expected 0000",
                   {bus_a.cmd_ready, bus_a.ENABLE, bus_a.CS_N, bus_a.RS});
        else n_pass++;
      end
      if (c == 2) begin
        n_checks++;
        if ({bus_a.ENABLE, bus_a.RS, bus_a.R_OR_W, bus_a.D_OE, bus_a.CS_N, bus_a.D_OUT} !== {5'b10010, 8'h0E})
          $display("FAIL wr_addr_en: got %b/%h expected 10010/0e",
                   {bus_a.ENABLE, bus_a.RS, bus_a.R_OR_W, bus_a.D_OE, bus_a.CS_N}, bus_a.D_OUT);
        else n_pass++;
      end
      if (c == 3) begin
        n_checks++;
        if ({bus_a.ENABLE, bus_a.CS_N, bus_a.RS} !== 3'b000)
          $display("FAIL wr_addr_hold: got %b expected 000", {bus_a.ENABLE, bus_a.CS_N, bus_a.RS});
        else n_pass++;
      end
      if (c == 5) begin
        n_checks++;
        if ({bus_a.ENABLE, bus_a.RS, bus_a.R_OR_W, bus_a.D_OE, bus_a.CS_N, bus_a.D_OUT} !== {5'b11010, 8'h55})
          $display("FAIL wr_data_en: got %b/%h expected 11010/55",
                   {bus_a.ENABLE, bus_a.RS, bus_a.R_OR_W, bus_a.D_OE, bus_a.CS_N}, bus_a.D_OUT);
        else n_pass++;
      end
      if (c == 7) begin
        n_checks++;
        if ({bus_a.cmd_ready, bus_a.CS_N, bus_a.D_OE} !== 3'b110)
          $display("FAIL wr_c7_idle: got %b expected 110", {bus_a.cmd_ready, bus_a.CS_N, bus_a.D_OE});
        else n_pass++;
      end
      if (c < 7) tick;
    end
    n_checks++;
    if (rsp_seen !== 0) $display("FAIL wr_no_rsp: got %0d pulses expected 0", rsp_seen);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_read;
    bus_a.cmd_valid = 1'b1; bus_a.cmd_write = 1'b0;
    bus_a.cmd_register = 5'h10; bus_a.cmd_data = 8'h00;
    tick;
    bus_a.cmd_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 4) begin
        n_checks++;
        if ({bus_a.R_OR_W, bus_a.D_OE, bus_a.RS, bus_a.CS_N, bus_a.D_OUT} !== {4'b1010, 8'hFF})
          $display("FAIL rd_setup: got %b/%h expected 1010/ff",
                   {bus_a.R_OR_W, bus_a.D_OE, bus_a.RS, bus_a.CS_N}, bus_a.D_OUT);
        else n_pass++;
      end
      if (c == 5) begin
        n_checks++;
        if ({bus_a.ENABLE, bus_a.R_OR_W, bus_a.D_OE, bus_a.rsp_data} !== {3'b110, 8'h00})
          $display("FAIL rd_en: got %b/%h expected 110/00",
                   {bus_a.ENABLE, bus_a.R_OR_W, bus_a.D_OE}, bus_a.rsp_data);
        else n_pass++;
        bus_a.D_IN = 8'hA5;
      end
      if (c == 6) begin
        bus_a.D_IN = 8'hFF;
        n_checks++;
        if ({bus_a.rsp_valid, bus_a.rsp_data} !== {1'b1, 8'hA5})
          $display("FAIL rd_rsp: got %b/%h expected 1/a5", bus_a.rsp_valid, bus_a.rsp_data);
        else n_pass++;
      end
      if (c == 7) begin
        n_checks++;
        if ({bus_a.rsp_valid, bus_a.cmd_ready, bus_a.rsp_data} !== {2'b01, 8'hA5})
          $display("FAIL rd_hold_data: got %b%b/%h expected 01/a5",
                   bus_a.rsp_valid, bus_a.cmd_ready, bus_a.rsp_data);
        else n_pass++;
      end
      if (c < 7) tick;
    end
    tick;
    n_checks++;
    if (bus_a.rsp_data !== 8'hA5) $display("FAIL rd_data_kept: got %h expected a5", bus_a.rsp_data);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] seen[$];
    int accepts = 0, last_acc = -1, bad_period = 0, bad_cs = 0, cs_hi = 0, bad_seq = 0;
    bit started = 0;
    bit acc;
    bus_a.cmd_valid = 1'b1; bus_a.cmd_write = 1'b1;
    bus_a.cmd_register = 5'd0; bus_a.cmd_data = 8'h55;
    for (int cyc = 0; cyc < 140; cyc++) begin
      acc = bus_a.cmd_valid && bus_a.cmd_ready;
      tick;
      if (acc) begin
        if (last_acc >= 0 && (cyc - last_acc) != 7) bad_period++;
        last_acc = cyc;
        accepts++;
        if (accepts < 18) bus_a.cmd_register = 5'(accepts);
        else bus_a.cmd_valid = 1'b0;
      end
      if (bus_a.ENABLE && !bus_a.RS) seen.push_back(bus_a.D_OUT);
      if (bus_a.CS_N) cs_hi++;
      else begin
        if (started && cs_hi != 0 && cs_hi != 1) bad_cs++;
        if (cs_hi != 0) started = 1;
        cs_hi = 0;
      end
    end
    n_checks++;
    if (accepts !== 18) $display("FAIL b2b_accepts: got %0d expected 18", accepts);
    else n_pass++;
    n_checks++;
    if (bad_period !== 0) $display("FAIL b2b_period: got %0d non-7 gaps expected 0", bad_period);
    else n_pass++;
    n_checks++;
    if (bad_cs !== 0) $display("FAIL b2b_cs_gap: got %0d bad gaps expected 0", bad_cs);
    else n_pass++;
    for (int i = 0; i < seen.size() && i < 18; i++)
      if (seen[i] !== 8'(i)) bad_seq++;
    n_checks++;
    if (seen.size() !== 18 || bad_seq !== 0)
      $display("FAIL b2b_addr_pulses: got %0d pulses %0d wrong expected 18 pulses 0 wrong",
               seen.size(), bad_seq);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_cache;
    int cyc, aen;
    run_b(5'h0C, 8'h11, cyc, aen);
    n_checks++;
    if (cyc !== 13 || aen !== 3)
      $display("FAIL cache_first: got %0d cycles %0d addr-en expected 13/3", cyc, aen);
    else n_pass++;
    run_b(5'h0C, 8'h22, cyc, aen);
    n_checks++;
    if (cyc !== HIT_CYCLES || aen !== HIT_ADDR)
      $display("FAIL cache_repeat: got %0d cycles %0d addr-en expected %0d/%0d",
               cyc, aen, HIT_CYCLES, HIT_ADDR);
    else n_pass++;
    run_b(5'h0D, 8'h33, cyc, aen);
    n_checks++;
    if (cyc !== 13 || aen !== 3)
      $display("FAIL cache_new_reg: got %0d cycles %0d addr-en expected 13/3", cyc, aen);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    int cyc, aen, rsp_seen = 0;
    bus_a.cmd_valid = 1'b1; bus_a.cmd_write = 1'b0;
    bus_a.cmd_register = 5'h07;
    tick;
    bus_a.cmd_valid = 1'b0;
    repeat (4) tick;
    n_checks++;
    if ({bus_a.ENABLE, bus_a.RS, bus_a.R_OR_W} !== 3'b111)
      $display("FAIL mid_in_d_en: got %b expected 111", {bus_a.ENABLE, bus_a.RS, bus_a.R_OR_W});
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.CS_N, bus_a.RS, bus_a.ENABLE, bus_a.R_OR_W, bus_a.D_OE, bus_a.cmd_ready,
         bus_a.rsp_valid, bus_a.D_OUT, bus_a.rsp_data} !== {7'b1101000, 8'hFF, 8'h00})
      $display("FAIL mid_async_idle: got %b/%h/%h expected 1101000/ff/00",
               {bus_a.CS_N, bus_a.RS, bus_a.ENABLE, bus_a.R_OR_W, bus_a.D_OE,
                bus_a.cmd_ready, bus_a.rsp_valid}, bus_a.D_OUT, bus_a.rsp_data);
    else n_pass++;
    repeat (3) begin
      tick;
      if (bus_a.rsp_valid) rsp_seen++;
    end
    reset_n = 1'b1;
    tick;
    if (bus_a.rsp_valid) rsp_seen++;
    n_checks++;
    if (rsp_seen !== 0 || bus_a.cmd_ready !== 1'b1)
      $display("FAIL mid_recover: got %0d rsp, ready %b expected 0 rsp, ready 1",
               rsp_seen, bus_a.cmd_ready);
    else n_pass++;
    run_a(1'b0, 5'h07, 8'h00, cyc, aen);
    n_checks++;
    if (cyc !== 7 || aen !== 1)
      $display("FAIL mid_full_addr: got %0d cycles %0d addr-en expected 7/1", cyc, aen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_cache();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
